uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync2.sv | 35 +++
 rtl/uart_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver:
//   - uart_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - DATA_BITS    : payload width of one frame
//   - START_LVL    : line level of the start bit
//   - STOP_LVL     : line level of the stop bit (also the idle level)
//   - parity_of()  : even parity of a data word (XOR reduce)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// RESET_VAL so an idle-high line does not look like an edge after reset.
// Ports:
//   clk     : destination clock
//   rst     : asynchronous active-high reset
//   async_i : asynchronous input
//   sync_o  : synchronised output (two clk of latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= RESET_VAL;
      ff2_q <= RESET_VAL;
    end else begin
      ff1_q <= async_i;
      ff2_q <= ff1_q;
    end
  end

  assign sync_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit (0), 8 data bits LSB first, optional even parity
// bit, 1 stop bit (1). Bits are timed by a shared OVERSAMPLE x baud tick.
// Each received byte is presented with a one-cycle rx_valid pulse together
// with its parity and framing error flags; data and flags hold until the next
// rx_valid. A byte is delivered even when a flag is set.
//
// Parameters:
//   PARITY_EN  : 1 = parity bit expected between data and stop, 0 = none
//   OVERSAMPLE : os_tick pulses per bit period (even, >= 4; >= 8 with voting)
//
// Ports:
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   os_tick       : one-clk pulse at OVERSAMPLE x baud rate
//   rx_line       : asynchronous serial input, idle high
//   rx_data       : last received byte
//   rx_valid      : one-clk pulse, rx_data and flags valid this cycle
//   rx_parity_err : parity mismatch on the last frame (0 when PARITY_EN=0)
//   rx_frame_err  : stop bit sampled low on the last frame
//   rx_busy       : high from start-bit detection until return to IDLE
//
// Build option:
//   UART_RX_MAJORITY_EN : when defined, every bit is the majority of three
//   samples around mid-bit, decided one os_tick after mid-bit.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int PARITY_EN  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int SCW = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_EN
  // The vote is decided one tick after the nominal mid-bit of the start bit.
  // Every later bit is then decided a whole bit period after the previous
  // decision, so the three samples (decision-2 .. decision) stay centred on
  // the bit and the one-tick offset does not accumulate across the frame.
  localparam logic [SCW-1:0] DEC_START = SCW'(OVERSAMPLE/2);
  localparam logic [SCW-1:0] DEC_BIT   = SCW'(OVERSAMPLE-1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and >= 8 with majority voting");
  end
`else
  localparam logic [SCW-1:0] DEC_START = SCW'(OVERSAMPLE/2 - 1);
  localparam logic [SCW-1:0] DEC_BIT   = SCW'(OVERSAMPLE-1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_s;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_line),
    .sync_o  (rx_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uart_state_e          state_q,     state_d;
  logic [SCW-1:0]       sc_q,        sc_d;
  logic [2:0]           bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 par_err_q,   par_err_d;
  logic                 rx_s_prev_q;
  logic [7:0]           rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 rx_perr_q,   rx_perr_d;
  logic                 rx_ferr_q,   rx_ferr_d;

  logic bit_tick;   // decision tick of the current bit
  logic bit_val;    // sampled (or voted) bit value at bit_tick
  logic start_edge;

`ifdef UART_RX_MAJORITY_EN
  // Samples from the two os_ticks preceding the current one.
  logic [1:0] samp_q, samp_d;

  always_comb begin
    samp_d = samp_q;
    if (os_tick) begin
      samp_d = {samp_q[0], rx_s};
    end
  end

  assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign bit_tick = os_tick && (sc_q == ((state_q == START) ? DEC_START : DEC_BIT));

  // rx_s_prev_q resets low and only follows rx_s afterwards, so a falling
  // edge can only be seen once the line has actually been observed high.
  // After a break the line stays low in IDLE and nothing retriggers.
  assign start_edge = rx_s_prev_q && (rx_s == START_LVL);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;

    if (os_tick) begin
      sc_d = sc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        sc_d = '0;
        if (start_edge) begin
          state_d = START;
        end
      end

      START: begin
        if (bit_tick) begin
          sc_d = '0;
          if (bit_val == START_LVL) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end else begin
            // False start: no pulse, flags untouched.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (bit_tick) begin
          sc_d      = '0;
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS-1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        if (bit_tick) begin
          sc_d      = '0;
          par_err_d = bit_val ^ parity_of(shift_q);
          state_d   = STOP;
        end
      end

      STOP: begin
        if (bit_tick) begin
          sc_d       = '0;
          // Back to IDLE at mid-stop so a start bit immediately following
          // the stop bit is still caught on its falling edge.
          state_d    = IDLE;
          rx_data_d  = shift_q;
          rx_perr_d  = (PARITY_EN != 0) ? par_err_q : 1'b0;
          rx_ferr_d  = (bit_val != STOP_LVL);
          rx_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sc_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      rx_s_prev_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      rx_s_prev_q <= rx_s;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= 2'b11;
    end else begin
      samp_q <= samp_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  // Drops in the same cycle rx_valid pulses, since STOP hands over to IDLE
  // on the same edge that registers the delivered byte.
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Two receivers share clock, reset and os_tick: dut_p expects a parity bit,
// dut_n does not. Frames are built bit by bit from the serial format; the
// expected byte and flags are queued when a frame is issued and checked by a
// per-receiver monitor whenever rx_valid pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_tick = 1'b0;
  logic       line_p = 1'b1;
  logic       line_n = 1'b1;

  logic [7:0] data_p, data_n;
  logic       valid_p, valid_n;
  logic       perr_p, perr_n;
  logic       ferr_p, ferr_n;
  logic       busy_p, busy_n;

  int total = 0;
  int bad   = 0;

  exp_t q_p[$];
  exp_t q_n[$];

  uart_rx #(.PARITY_EN(1), .OVERSAMPLE(OS)) dut_p (
    .clk           (clk),
    .rst           (rst),
    .os_tick       (os_tick),
    .rx_line       (line_p),
    .rx_data       (data_p),
    .rx_valid      (valid_p),
    .rx_parity_err (perr_p),
    .rx_frame_err  (ferr_p),
    .rx_busy       (busy_p)
  );

  uart_rx #(.PARITY_EN(0), .OVERSAMPLE(OS)) dut_n (
    .clk           (clk),
    .rst           (rst),
    .os_tick       (os_tick),
    .rx_line       (line_n),
    .rx_data       (data_n),
    .rx_valid      (valid_n),
    .rx_parity_err (perr_n),
    .rx_frame_err  (ferr_n),
    .rx_busy       (busy_n)
  );

  always #5 clk = ~clk;

  // os_tick changes on the falling edge so it is stable at every rising edge.
  int div_cnt = 0;
  always @(negedge clk) begin
    div_cnt <= (div_cnt == TICK_DIV-1) ? 0 : div_cnt + 1;
    os_tick <= (div_cnt == TICK_DIV-1);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Wait for n os_tick rising edges, then step 1 time unit past the edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (os_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) line_p = b;
    else          line_n = b;
  endtask

  // sel 0 -> parity receiver, 1 -> no-parity receiver.
  // spike_bit: frame bit position that gets a one-tick inverted spike mid-bit.
  // abort_bit: frame bit position at whose middle the task stops (no expect).
  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_flip,
                            input logic stop_val, input int spike_bit, input int abort_bit);
    logic bits [11];
    int   nb;
    int   ones;
    exp_t e;
    bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bits[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (sel == 0) begin
      bits[9]  = ((ones % 2) == 1) ^ par_flip;
      ones    += int'(bits[9]);
      bits[10] = stop_val;
      nb       = 11;
    end else begin
      bits[9] = stop_val;
      nb      = 10;
    end
    e.d  = d;
    e.pe = (sel == 0) ? ((ones % 2) == 1) : 1'b0;
    e.fe = (stop_val == 1'b0);
    if (abort_bit < 0) begin
      if (sel == 0) q_p.push_back(e);
      else          q_n.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      drive(sel, bits[b]);
      if (b == abort_bit) begin
        wait_ticks(OS/2);
        return;
      end else if (b == spike_bit) begin
        wait_ticks(OS/2 - 1);
        drive(sel, ~bits[b]);
        wait_ticks(1);
        drive(sel, bits[b]);
        wait_ticks(OS/2);
      end else begin
        wait_ticks(OS);
      end
    end
  endtask

  task automatic idle(input int sel, input int nbits);
    drive(sel, 1'b1);
    wait_ticks(nbits * OS);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (valid_p === 1'b1) begin
      if (q_p.size() == 0) begin
        total++;
        bad++;
        $display("FAIL p_unexpected_valid: got data %02h, expected no frame", data_p);
      end else begin
        exp_t e;
        e = q_p.pop_front();
        $display("rx p: data=%02h pe=%0b fe=%0b (exp %02h %0b %0b)", data_p, perr_p, ferr_p, e.d, e.pe, e.fe);
        cmp("p_data", 32'(data_p), 32'(e.d));
        cmp("p_parity_err", 32'(perr_p), 32'(e.pe));
        cmp("p_frame_err", 32'(ferr_p), 32'(e.fe));
        cmp("p_busy_at_valid", 32'(busy_p), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_n === 1'b1) begin
      if (q_n.size() == 0) begin
        total++;
        bad++;
        $display("FAIL n_unexpected_valid: got data %02h, expected no frame", data_n);
      end else begin
        exp_t e;
        e = q_n.pop_front();
        $display("rx n: data=%02h pe=%0b fe=%0b (exp %02h %0b %0b)", data_n, perr_n, ferr_n, e.d, e.pe, e.fe);
        cmp("n_data", 32'(data_n), 32'(e.d));
        cmp("n_parity_err", 32'(perr_n), 32'(e.pe));
        cmp("n_frame_err", 32'(ferr_n), 32'(e.fe));
        cmp("n_busy_at_valid", 32'(busy_n), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    exp_t brk;

    // Reset state
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cmp("reset_data", 32'(data_p), 32'd0);
    cmp("reset_valid", 32'(valid_p), 32'd0);
    cmp("reset_parity_err", 32'(perr_p), 32'd0);
    cmp("reset_frame_err", 32'(ferr_p), 32'd0);
    cmp("reset_busy", 32'(busy_p), 32'd0);
    rst = 1'b0;
    wait_ticks(2 * OS);

    // 1: plain 0xA5 with parity
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1, -1);
    idle(0, 1);

    // 2: bad parity, then a clean frame clears the flag
    send_frame(0, 8'h3C, 1'b1, 1'b1, -1, -1);
    idle(0, 1);
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1, -1);
    idle(0, 1);

    // 3: stop bit low, then a 20-bit break yields exactly one 0x00 frame
    send_frame(0, 8'h81, 1'b0, 1'b0, -1, -1);
    idle(0, 2);
    brk.d  = 8'h00;
    brk.pe = 1'b0;
    brk.fe = 1'b1;
    q_p.push_back(brk);
    drive(0, 1'b0);
    wait_ticks(20 * OS);
    idle(0, 2);

    // 4: 4-tick low glitch is a false start
    drive(0, 1'b0);
    wait_ticks(4);
    cmp("glitch_busy_high", 32'(busy_p), 32'd1);
    idle(0, 2);
    cmp("glitch_back_idle", 32'(busy_p), 32'd0);
`ifdef UART_RX_MAJORITY_EN
    // one-tick high spike in the middle of data bit 3 is voted away
    send_frame(0, 8'h00, 1'b0, 1'b1, 4, -1);
    idle(0, 1);
`endif

    // 5: back-to-back frames, no parity, no idle gap
    send_frame(1, 8'h55, 1'b0, 1'b1, -1, -1);
    send_frame(1, 8'hAA, 1'b0, 1'b1, -1, -1);
    send_frame(1, 8'hFF, 1'b0, 1'b1, -1, -1);
    idle(1, 1);

    // 6: reset in the middle of data bit 4
    send_frame(0, 8'hC3, 1'b0, 1'b1, -1, -1);
    idle(0, 1);
    send_frame(0, 8'h6B, 1'b0, 1'b1, -1, 5);
    cmp("abort_busy_before_rst", 32'(busy_p), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    cmp("rst_data", 32'(data_p), 32'd0);
    cmp("rst_valid", 32'(valid_p), 32'd0);
    cmp("rst_parity_err", 32'(perr_p), 32'd0);
    cmp("rst_frame_err", 32'(ferr_p), 32'd0);
    cmp("rst_busy", 32'(busy_p), 32'd0);
    line_p = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(2 * OS);
    send_frame(0, 8'h12, 1'b0, 1'b1, -1, -1);
    idle(0, 1);

    // Random frames on both receivers
    for (int i = 0; i < 24; i++) begin
      int         sel;
      logic [7:0] d;
      logic       pf;
      logic       sv;
      int         gap;
      sel = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      pf  = (sel == 0) && ($urandom_range(0, 4) == 0);
      sv  = ($urandom_range(0, 5) != 0);
      gap = int'($urandom_range(0, 2));
      if (!sv && gap == 0) gap = 1;
      send_frame(sel, d, pf, sv, -1, -1);
      idle(sel, gap);
    end

    idle(0, 2);
    idle(1, 1);
    cmp("p_all_frames_seen", 32'(q_p.size()), 32'd0);
    cmp("n_all_frames_seen", 32'(q_n.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
